// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT input path.
package fft_pkg;

   localparam int N_POINTS = 16;
   localparam int T_W      = 16;
   localparam int TMAX_FFT = 511;
   localparam int TMIN_FFT = -512;
   localparam int HALF     = N_POINTS / 2;
   localparam int FILL_W   = $clog2(N_POINTS + 1);
   localparam int SLOT_W   = $clog2(N_POINTS);

   typedef logic signed [T_W-1:0] t_word_t;
   typedef t_word_t frame_t [N_POINTS];

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } fb_state_t;

endpackage

// File: rtl/sample_conditioner.sv
// Arithmetic right shift, clamp to the FFT input range, sign-extend to T_W.
module sample_conditioner
   import fft_pkg::*;
#(
   parameter int IN_W  = 24,
   parameter int SHIFT = 13
) (
   input  logic [IN_W-1:0] sample_in,
   output t_word_t         t_word
);

   localparam logic signed [IN_W-1:0] HI = IN_W'(TMAX_FFT);
   localparam logic signed [IN_W-1:0] LO = IN_W'(TMIN_FFT);

   logic signed [IN_W-1:0] shifted;
   logic signed [IN_W-1:0] clamped;

   always_comb begin
      shifted = $signed(sample_in) >>> SHIFT;
      if (shifted > HI)
         clamped = HI;
      else if (shifted < LO)
         clamped = LO;
      else
         clamped = shifted;
      // clamped lies in [-512, 511], so resizing keeps the sign
      t_word = T_W'(clamped);
   end

endmodule

// File: rtl/fft_frame_builder.sv
// Collects conditioned samples into 16-point frames and issues them to the FFT.
// Optional macro FFT_OVERLAP_EN: 50% frame overlap (new frame every 8 samples).
//
// state | meaning
// IDLE  | no frame outstanding; a full fill launches immediately
// BUSY  | frame issued, waiting for fft_done; next fill continues behind it
module fft_frame_builder
   import fft_pkg::*;
#(
   parameter int IN_W  = 24,
   parameter int SHIFT = 13
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sample_valid,
   input  logic [IN_W-1:0]         sample_in,
   output logic                    sample_ready,
   input  logic                    fft_done,
   output logic                    new_t,
   output logic [N_POINTS*T_W-1:0] t_frame,
   output logic                    fft_busy,
   output logic                    overflow,
   input  logic                    clr_ovf,
   output logic [7:0]              drop_cnt,
   output logic [15:0]             frame_cnt
);

   localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(N_POINTS);
`ifdef FFT_OVERLAP_EN
   localparam logic [FILL_W-1:0] RESTART  = FILL_W'(HALF);
`else
   localparam logic [FILL_W-1:0] RESTART  = '0;
`endif
   localparam logic [SLOT_W-1:0] RESTART_SLOT = RESTART[SLOT_W-1:0];

   fb_state_t                state_q, state_d;
   logic [FILL_W-1:0]        fill_cnt_q;
   frame_t                   fill_q;
   logic [N_POINTS*T_W-1:0]  fill_packed;
   logic [N_POINTS*T_W-1:0]  t_frame_q;
   logic                     new_t_q;
   logic                     overflow_q;
   logic [7:0]               drop_cnt_q;
   logic [15:0]              frame_cnt_q;
   t_word_t                  cond_word;
   logic [SLOT_W-1:0]        wr_slot;
   logic                     full, launch, accept, drop;

   sample_conditioner #(
      .IN_W  (IN_W),
      .SHIFT (SHIFT)
   ) u_cond (
      .sample_in (sample_in),
      .t_word    (cond_word)
   );

   assign full         = (fill_cnt_q == FULL_CNT);
   assign launch       = full && ((state_q == IDLE) || fft_done);
   assign sample_ready = !full || launch;
   assign accept       = sample_valid && sample_ready;
   assign drop         = sample_valid && !sample_ready;
   assign wr_slot      = launch ? RESTART_SLOT : fill_cnt_q[SLOT_W-1:0];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (launch) state_d = BUSY;
         BUSY: if (fft_done && !launch) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fill_packed = '0;
      for (int i = 0; i < N_POINTS; i++)
         fill_packed[i*T_W +: T_W] = fill_q[i];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         fill_cnt_q  <= '0;
         t_frame_q   <= '0;
         new_t_q     <= 1'b0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         new_t_q <= launch;
         if (launch) begin
            t_frame_q   <= fill_packed;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            fill_cnt_q  <= RESTART + FILL_W'(accept);
         end else if (accept) begin
            fill_cnt_q  <= fill_cnt_q + 1'b1;
         end
         // a drop in the same cycle as clr_ovf restarts the count at one
         if (drop) begin
            overflow_q <= 1'b1;
            if (clr_ovf)
               drop_cnt_q <= 8'd1;
            else if (drop_cnt_q != 8'hFF)
               drop_cnt_q <= drop_cnt_q + 8'd1;
         end else if (clr_ovf) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
         end
      end
   end

   // Fill storage is don't-care after reset; fill_cnt alone tracks validity.
   always_ff @(posedge clk) begin
`ifdef FFT_OVERLAP_EN
      if (launch) begin
         for (int i = 0; i < HALF; i++)
            fill_q[i] <= fill_q[i+HALF];
      end
`endif
      if (accept)
         fill_q[wr_slot] <= cond_word;
   end

   assign t_frame   = t_frame_q;
   assign new_t     = new_t_q;
   assign fft_busy  = (state_q == BUSY);
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_builder.sv
// Randomized self-checking bench for fft_frame_builder against a queue-based model.
module tb_fft_frame_builder;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          sample_valid = 1'b0;
   logic [23:0]   sample_in = '0;
   logic          sample_ready;
   logic          fft_done = 1'b0;
   logic          new_t;
   logic [255:0]  t_frame;
   logic          fft_busy;
   logic          overflow;
   logic          clr_ovf = 1'b0;
   logic [7:0]    drop_cnt;
   logic [15:0]   frame_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   fft_frame_builder dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_in    (sample_in),
      .sample_ready (sample_ready),
      .fft_done     (fft_done),
      .new_t        (new_t),
      .t_frame      (t_frame),
      .fft_busy     (fft_busy),
      .overflow     (overflow),
      .clr_ovf      (clr_ovf),
      .drop_cnt     (drop_cnt),
      .frame_cnt    (frame_cnt)
   );

   always #5 clk = ~clk;

`ifdef FFT_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   // reference model state
   int          m_fill[$];
   int          m_tframe[16];
   bit          m_busy, m_new_t, m_ovf;
   int          m_drop;
   logic [15:0] m_frames;
   bit          dut_rdy, mdl_rdy;

   function automatic int cond(input logic [23:0] s);
      int v;
      v = int'($signed(s));
      v = v >>> 13;
      if (v > 511) v = 511;
      if (v < -512) v = -512;
      return v;
   endfunction

   function automatic logic [255:0] exp_frame();
      logic [255:0] f;
      for (int i = 0; i < 16; i++) f[i*16 +: 16] = 16'(m_tframe[i]);
      return f;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; sample_valid = 1'b0; fft_done = 1'b0; clr_ovf = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      m_fill.delete();
      for (int i = 0; i < 16; i++) m_tframe[i] = 0;
      m_busy = 0; m_new_t = 0; m_ovf = 0; m_drop = 0; m_frames = '0;
   endtask

   task automatic cycle(input bit v, input logic [23:0] s, input bit d, input bit c);
      bit full, launch;
      @(negedge clk);
      sample_valid = v; sample_in = s; fft_done = d; clr_ovf = c;
      full   = (m_fill.size() == 16);
      launch = full && (!m_busy || d);
      mdl_rdy = !full || launch;
      #1 dut_rdy = sample_ready;
      @(posedge clk);
      if (launch) begin
         for (int i = 0; i < 16; i++) m_tframe[i] = m_fill[i];
         m_frames = m_frames + 16'd1;
         m_busy = 1;
         if (OVL) m_fill = m_fill[8:15];
         else m_fill.delete();
      end else if (m_busy && d) begin
         m_busy = 0;
      end
      m_new_t = launch;
      if (v && mdl_rdy) m_fill.push_back(cond(s));
      if (v && !mdl_rdy) begin
         m_ovf = 1;
         m_drop = c ? 1 : (m_drop == 255 ? 255 : m_drop + 1);
      end else if (c) begin
         m_ovf = 0; m_drop = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (new_t !== 1'b0) begin n_bad++; $display("FAIL reset_new_t got %b want 0", new_t); end
      n_cmp++; if (t_frame !== 256'd0) begin n_bad++; $display("FAIL reset_t_frame got %h want 0", t_frame); end
      n_cmp++; if (fft_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", fft_busy); end
      n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_ovf got %b/%0d want 0/0", overflow, drop_cnt); end
      n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
      n_cmp++; if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", sample_ready); end
   endtask

   task automatic test_first_frame();
      logic [255:0] want;
      for (int i = 0; i < 16; i++) want[i*16 +: 16] = 16'h01FF;
      for (int i = 0; i < 16; i++) cycle(1, 24'h3FFFFF, 0, 0);
      n_cmp++; if (new_t !== 1'b0) begin n_bad++; $display("FAIL first_early_new_t got %b want 0", new_t); end
      cycle(0, 24'h0, 0, 0);
      n_cmp++; if (new_t !== 1'b1) begin n_bad++; $display("FAIL first_new_t got %b want 1", new_t); end
      n_cmp++; if (t_frame !== want) begin n_bad++; $display("FAIL first_t_frame got %h want %h", t_frame, want); end
      n_cmp++; if (fft_busy !== 1'b1) begin n_bad++; $display("FAIL first_busy got %b want 1", fft_busy); end
      n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL first_frame_cnt got %0d want 1", frame_cnt); end
      cycle(0, 24'h0, 0, 0);
      n_cmp++; if (new_t !== 1'b0) begin n_bad++; $display("FAIL first_pulse_width got %b want 0", new_t); end
   endtask

   task automatic test_overflow();
      logic [255:0] want;
      int want_drop;
      for (int i = 0; i < 16; i++) want[i*16 +: 16] = 16'h01FF;
      want_drop = OVL ? 12 : 4;
      for (int i = 0; i < 20; i++) cycle(1, 24'($urandom), 0, 0);
      n_cmp++; if (dut_rdy !== 1'b0) begin n_bad++; $display("FAIL ovf_ready got %b want 0", dut_rdy); end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
      n_cmp++; if (drop_cnt !== 8'(want_drop)) begin n_bad++; $display("FAIL ovf_drop_cnt got %0d want %0d", drop_cnt, want_drop); end
      n_cmp++; if (t_frame !== want) begin n_bad++; $display("FAIL ovf_t_frame_held got %h want %h", t_frame, want); end
      cycle(0, 24'h0, 1, 0);
      n_cmp++; if (new_t !== 1'b1 || fft_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_launch got new_t=%b busy=%b want 1/1", new_t, fft_busy); end
      n_cmp++; if (frame_cnt !== 16'd2) begin n_bad++; $display("FAIL b2b_frame_cnt got %0d want 2", frame_cnt); end
      n_cmp++; if (t_frame !== exp_frame()) begin n_bad++; $display("FAIL b2b_t_frame got %h want %h", t_frame, exp_frame()); end
      cycle(0, 24'h0, 0, 1);
      n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_bad++; $display("FAIL clr_ovf got %b/%0d want 0/0", overflow, drop_cnt); end
      while (m_fill.size() < 16) cycle(1, 24'($urandom), 0, 0);
      cycle(1, 24'($urandom), 0, 1);
      n_cmp++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin n_bad++; $display("FAIL clr_vs_drop got %b/%0d want 1/1", overflow, drop_cnt); end
   endtask

   task automatic test_saturation();
      logic [23:0] pat[16];
      logic [15:0] want[4];
      pat[0] = 24'h7FFFFF; pat[1] = 24'h800000; pat[2] = 24'hFFE000; pat[3] = 24'h004000;
      want[0] = 16'h01FF; want[1] = 16'hFE00; want[2] = 16'hFFFF; want[3] = 16'h0002;
      for (int i = 4; i < 16; i++) pat[i] = 24'($urandom);
      do_reset();
      for (int i = 0; i < 16; i++) cycle(1, pat[i], 0, 0);
      cycle(0, 24'h0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (t_frame[i*16 +: 16] !== want[i]) begin n_bad++; $display("FAIL sat_word%0d got %h want %h", i, t_frame[i*16 +: 16], want[i]); end
      end
      n_cmp++; if (t_frame !== exp_frame()) begin n_bad++; $display("FAIL sat_frame got %h want %h", t_frame, exp_frame()); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 7; i++) cycle(1, 24'($urandom), 0, 0);
      do_reset();
      n_cmp++; if (t_frame !== 256'd0 || new_t !== 1'b0 || fft_busy !== 1'b0 || frame_cnt !== 16'd0)
         begin n_bad++; $display("FAIL midrst_outputs got busy=%b cnt=%0d want 0/0", fft_busy, frame_cnt); end
      for (int i = 0; i < 16; i++) cycle(1, 24'($urandom), 1, 0);
      cycle(0, 24'h0, 0, 0);
      n_cmp++; if (new_t !== 1'b1 || frame_cnt !== 16'd1) begin n_bad++; $display("FAIL midrst_launch got new_t=%b cnt=%0d want 1/1", new_t, frame_cnt); end
      n_cmp++; if (t_frame !== exp_frame()) begin n_bad++; $display("FAIL midrst_frame got %h want %h", t_frame, exp_frame()); end
   endtask

   task automatic test_ramp();
      logic [255:0] want1, want2, got1, got2;
      int seen;
      bit d;
      seen = 0; d = 0; got1 = '0; got2 = '0;
      for (int i = 0; i < 16; i++) begin
         want1[i*16 +: 16] = 16'(i);
         want2[i*16 +: 16] = 16'(i + 8);
      end
      do_reset();
      for (int i = 0; i < 27; i++) begin
         cycle(i < 24, 24'(i << 13), d, 0);
         d = m_new_t;
         if (new_t === 1'b1) begin
            if (seen == 0) got1 = t_frame; else got2 = t_frame;
            seen++;
         end
      end
      n_cmp++; if (got1 !== want1) begin n_bad++; $display("FAIL ramp_frame1 got %h want %h", got1, want1); end
      if (OVL) begin
         n_cmp++; if (got2 !== want2) begin n_bad++; $display("FAIL ramp_frame2 got %h want %h", got2, want2); end
      end
      n_cmp++; if (frame_cnt !== (OVL ? 16'd2 : 16'd1)) begin n_bad++; $display("FAIL ramp_frame_cnt got %0d want %0d", frame_cnt, OVL ? 2 : 1); end
   endtask

   task automatic test_random();
      bit v, d, c;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         v = ($urandom_range(0, 9) < 8);
         d = ($urandom_range(0, 9) < 2);
         c = ($urandom_range(0, 49) == 0);
         cycle(v, 24'($urandom), d, c);
         n_cmp++; if (dut_rdy !== mdl_rdy) begin n_bad++; $display("FAIL rnd_ready @%0d got %b want %b", n, dut_rdy, mdl_rdy); end
         n_cmp++; if (new_t !== m_new_t || fft_busy !== m_busy) begin n_bad++; $display("FAIL rnd_ctrl @%0d got %b%b want %b%b", n, new_t, fft_busy, m_new_t, m_busy); end
         n_cmp++; if (t_frame !== exp_frame()) begin n_bad++; $display("FAIL rnd_frame @%0d got %h want %h", n, t_frame, exp_frame()); end
         n_cmp++; if (overflow !== m_ovf || drop_cnt !== 8'(m_drop) || frame_cnt !== m_frames)
            begin n_bad++; $display("FAIL rnd_status @%0d got %b/%0d/%0d want %b/%0d/%0d", n, overflow, drop_cnt, frame_cnt, m_ovf, m_drop, m_frames); end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_overflow();
      test_saturation();
      test_mid_reset();
      test_ramp();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
